demux_pipeline: RTL and testbench

Registered 1-to-N demultiplexer for high-speed designs: routes one WIDTH-bit word with a valid qualifier to exactly one of OUTPUT_COUNT output lanes through a tree of DEMUX_SIZE-way fan-out stages, one register level per tree level. It is the distribution-side counterpart to the pipelined N-to-1 mux. It sits between a single producer and a bank of per-lane consumers. It accepts a new word every cycle with fixed latency for every lane.

---
 rtl/demux_pipeline_pkg.sv | 47 ++++
 rtl/demux_pipeline_node.sv | 68 ++++++
 rtl/demux_pipeline.sv | 84 ++++++++
 tb/tb_demux_pipeline.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/demux_pipeline_pkg.sv
// Shared constants and N-ary tree helpers for demux_pipeline.
package demux_pipeline_pkg;

  // Select width for a lane count; a single lane still carries one select bit.
  function automatic int unsigned f_sel_width(input int unsigned count);
    return (count <= 1) ? 1 : $clog2(count);
  endfunction

  // Register levels needed to consume all select bits, SB bits per level.
  function automatic int unsigned f_NaryLevelCount(input int unsigned count,
                                                   input int unsigned size);
    int unsigned sb;
    int unsigned lv;
    sb = $clog2(size);
    lv = (f_sel_width(count) + sb - 1) / sb;
    return (lv < 1) ? 1 : lv;
  endfunction

  // Bit offset of the select slice routed on at a given level (MSB slice first).
  function automatic int unsigned f_NarySelSliceBase(input int unsigned count,
                                                     input int unsigned size,
                                                     input int unsigned level);
    return (f_NaryLevelCount(count, size) - 1 - level) * $clog2(size);
  endfunction

  // Output slots instantiated by a level; level -1 stands for the single input.
  function automatic int unsigned f_NaryNodeCount(input int unsigned count,
                                                  input int unsigned size,
                                                  input int level);
    int unsigned span;
    span = 1;
    if (level < 0) return 1;
    for (int i = level + 1; i < int'(f_NaryLevelCount(count, size)); i++) span = span * size;
    return (count + span - 1) / span;
  endfunction

  // Children actually present under one node; trailing nodes may be partial.
  function automatic int unsigned f_NaryChildCount(input int unsigned count,
                                                   input int unsigned size,
                                                   input int level,
                                                   input int unsigned node);
    int unsigned rem;
    rem = f_NaryNodeCount(count, size, level) - node * size;
    return (rem < size) ? rem : size;
  endfunction

endpackage

// File: rtl/demux_pipeline_node.sv
// One registered 1-to-CHILDREN fan-out node of the demux tree.
// With DEMUX_PIPELINE_ZERO_EN defined, unselected children load 0 instead of holding.
module demux_pipeline_node #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned SB         = 1,
  parameter int unsigned PW         = 1,
  parameter int unsigned SLICE_BASE = 0,
  parameter int unsigned CHILDREN   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          data_i,
  input  logic                      valid_i,
  input  logic                      drop_i,
  input  logic [PW-1:0]             psel_i,
  output logic [CHILDREN*WIDTH-1:0] data_o,
  output logic [CHILDREN-1:0]       valid_o,
  output logic                      drop_o,
  output logic [PW-1:0]             psel_o
);

  logic [SB-1:0]             idx;
  logic [CHILDREN*WIDTH-1:0] data_d, data_q;
  logic [CHILDREN-1:0]       valid_d, valid_q;
  logic                      drop_d, drop_q;
  logic [PW-1:0]             psel_q;

  assign idx = psel_i[SLICE_BASE +: SB];

  // Steer the word to the selected child; a missing child turns it into a drop token.
  always_comb begin
    data_d  = data_q;
    valid_d = '0;
    drop_d  = drop_i || (valid_i && (int'(idx) >= int'(CHILDREN)));
    for (int c = 0; c < int'(CHILDREN); c++) begin
      if (valid_i && (int'(idx) == c)) begin
        valid_d[c]               = 1'b1;
        data_d[c*WIDTH +: WIDTH] = data_i;
      end
`ifdef DEMUX_PIPELINE_ZERO_EN
      else begin
        data_d[c*WIDTH +: WIDTH] = '0;
      end
`endif
    end
  end

  // Node state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= '0;
      drop_q  <= 1'b0;
      psel_q  <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
      psel_q  <= psel_i;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign drop_o  = drop_q;
  assign psel_o  = psel_q;

endmodule

// File: rtl/demux_pipeline.sv
// Registered 1-to-OUTPUT_COUNT demultiplexer built as a tree of DEMUX_SIZE-way nodes,
// one register level per tree level. Optional macro: DEMUX_PIPELINE_ZERO_EN.
module demux_pipeline
  import demux_pipeline_pkg::*;
#(
  parameter int unsigned WIDTH        = 4,
  parameter int unsigned OUTPUT_COUNT = 2,
  parameter int unsigned DEMUX_SIZE   = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [f_sel_width(OUTPUT_COUNT)-1:0] sel,
  input  logic [WIDTH-1:0]                in,
  input  logic                            in_valid,
  output logic [WIDTH*OUTPUT_COUNT-1:0]   out,
  output logic [OUTPUT_COUNT-1:0]         out_valid,
  output logic                            out_drop
);

  localparam int unsigned SB     = $clog2(DEMUX_SIZE);
  localparam int unsigned LEVELS = f_NaryLevelCount(OUTPUT_COUNT, DEMUX_SIZE);
  localparam int unsigned PW     = LEVELS * SB;

  logic [PW-1:0] psel;

  // A single lane has nowhere to steer, so sel is ignored there.
  assign psel = (OUTPUT_COUNT == 1) ? '0 : PW'(sel);

  for (genvar k = 0; k < int'(LEVELS); k++) begin : g_lvl
    localparam int unsigned NIn  = f_NaryNodeCount(OUTPUT_COUNT, DEMUX_SIZE, k - 1);
    localparam int unsigned NOut = f_NaryNodeCount(OUTPUT_COUNT, DEMUX_SIZE, k);

    logic [NOut*WIDTH-1:0] data;
    logic [NOut-1:0]       valid;
    logic [NIn-1:0]        drop;
    logic [NIn*PW-1:0]     psel_l;

    for (genvar j = 0; j < int'(NIn); j++) begin : g_node
      localparam int unsigned Ch = f_NaryChildCount(OUTPUT_COUNT, DEMUX_SIZE, k, j);

      logic [WIDTH-1:0] d_in;
      logic             v_in;
      logic             drop_in;
      logic [PW-1:0]    p_in;

      if (k == 0) begin : g_root
        assign d_in    = in;
        assign v_in    = in_valid;
        assign drop_in = 1'b0;
        assign p_in    = psel;
      end else begin : g_inner
        assign d_in    = g_lvl[k-1].data[j*WIDTH +: WIDTH];
        assign v_in    = g_lvl[k-1].valid[j];
        // Drop tokens from the whole previous level funnel into node 0; at most one exists.
        assign drop_in = (j == 0) ? |g_lvl[k-1].drop : 1'b0;
        assign p_in    = g_lvl[k-1].psel_l[(j/DEMUX_SIZE)*PW +: PW];
      end

      demux_pipeline_node #(
        .WIDTH     (WIDTH),
        .SB        (SB),
        .PW        (PW),
        .SLICE_BASE(f_NarySelSliceBase(OUTPUT_COUNT, DEMUX_SIZE, k)),
        .CHILDREN  (Ch)
      ) u_node (
        .clk    (clk),
        .rst    (rst),
        .data_i (d_in),
        .valid_i(v_in),
        .drop_i (drop_in),
        .psel_i (p_in),
        .data_o (data[j*DEMUX_SIZE*WIDTH +: Ch*WIDTH]),
        .valid_o(valid[j*DEMUX_SIZE +: Ch]),
        .drop_o (drop[j]),
        .psel_o (psel_l[j*PW +: PW])
      );
    end
  end

  assign out       = g_lvl[LEVELS-1].data;
  assign out_valid = g_lvl[LEVELS-1].valid;
  assign out_drop  = |g_lvl[LEVELS-1].drop;

endmodule

// File: tb/tb_demux_pipeline.sv
// Self-checking bench: three demux_pipeline configurations driven by shared stimulus and
// compared every cycle against a history-based reference model.
module tb_demux_pipeline;

  logic        clk;
  logic        rst;
  logic [3:0]  sel;
  logic [3:0]  in;
  logic        in_valid;

  logic [39:0] a_out, b_out;
  logic [9:0]  a_valid, b_valid;
  logic        a_drop, b_drop;
  logic [3:0]  c_out;
  logic [0:0]  c_valid;
  logic        c_drop;

  // A: 10 lanes, 2-way (4 levels). B: 10 lanes, 4-way (2 levels). C: 1 lane (1 level).
  demux_pipeline #(.WIDTH(4), .OUTPUT_COUNT(10), .DEMUX_SIZE(2)) u_a (
    .clk(clk), .rst(rst), .sel(sel), .in(in), .in_valid(in_valid),
    .out(a_out), .out_valid(a_valid), .out_drop(a_drop));

  demux_pipeline #(.WIDTH(4), .OUTPUT_COUNT(10), .DEMUX_SIZE(4)) u_b (
    .clk(clk), .rst(rst), .sel(sel), .in(in), .in_valid(in_valid),
    .out(b_out), .out_valid(b_valid), .out_drop(b_drop));

  demux_pipeline #(.WIDTH(4), .OUTPUT_COUNT(1), .DEMUX_SIZE(2)) u_c (
    .clk(clk), .rst(rst), .sel(sel[0]), .in(in), .in_valid(in_valid),
    .out(c_out), .out_valid(c_valid), .out_drop(c_drop));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Input history, indexed by the cycle in which each input was driven.
  logic       hv [4096];
  logic [3:0] hs [4096];
  logic [3:0] hd [4096];
  logic       hr [4096];
  int         cyc;

  logic [3:0] la [10];
  logic [3:0] lb [10];
  logic [3:0] lc;

  int n_pass;
  int n_total;

  task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
  endtask

  // Word driven in cycle n-L appears in cycle n unless a reset edge fell in between.
  task automatic expect_at(input int lat, input int n, output logic [9:0] ev,
                           output logic ed, output int lane, output logic [3:0] w);
    int src;
    src  = cyc - lat;
    ev   = '0;
    ed   = 1'b0;
    lane = -1;
    w    = '0;
    if (src < 0) return;
    for (int c = src; c < cyc; c++) if (hr[c]) return;
    if (!hv[src]) return;
    if (n == 1 || int'(hs[src]) < n) begin
      lane     = (n == 1) ? 0 : int'(hs[src]);
      ev[lane] = 1'b1;
      w        = hd[src];
    end else begin
      ed = 1'b1;
    end
  endtask

  function automatic logic [39:0] lanes_vec(input logic [3:0] l [10], input logic [9:0] ev);
    logic [39:0] v;
    v = '0;
    for (int i = 0; i < 10; i++) begin
      v[i*4 +: 4] = l[i];
`ifdef DEMUX_PIPELINE_ZERO_EN
      if (!ev[i]) v[i*4 +: 4] = '0;
`endif
    end
    return v;
  endfunction

  task automatic check_all();
    logic [9:0] ev;
    logic       ed;
    int         lane;
    logic [3:0] w;
    logic [3:0] cexp;
    // Lane A
    expect_at(4, 10, ev, ed, lane, w);
    if (hr[cyc-1]) for (int i = 0; i < 10; i++) la[i] = '0;
    if (lane >= 0) la[lane] = w;
    chk("a_valid", 40'(a_valid), 40'(ev));
    chk("a_drop", 40'(a_drop), 40'(ed));
    chk("a_data", a_out, lanes_vec(la, ev));
    // Lane B
    expect_at(2, 10, ev, ed, lane, w);
    if (hr[cyc-1]) for (int i = 0; i < 10; i++) lb[i] = '0;
    if (lane >= 0) lb[lane] = w;
    chk("b_valid", 40'(b_valid), 40'(ev));
    chk("b_drop", 40'(b_drop), 40'(ed));
    chk("b_data", b_out, lanes_vec(lb, ev));
    // Lane C
    expect_at(1, 1, ev, ed, lane, w);
    if (hr[cyc-1]) lc = '0;
    if (lane >= 0) lc = w;
    cexp = lc;
`ifdef DEMUX_PIPELINE_ZERO_EN
    if (!ev[0]) cexp = '0;
`endif
    chk("c_valid", 40'(c_valid), 40'(ev[0]));
    chk("c_drop", 40'(c_drop), 40'(ed));
    chk("c_data", 40'(c_out), 40'(cexp));
  endtask

  // Drive one cycle of inputs, advance past the edge, then check every DUT.
  task automatic step(input logic v, input logic [3:0] s, input logic [3:0] d, input logic r);
    in_valid = v;
    sel      = s;
    in       = d;
    rst      = r;
    hv[cyc]  = v;
    hs[cyc]  = s;
    hd[cyc]  = d;
    hr[cyc]  = r;
    @(posedge clk);
    #1;
    cyc++;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'($urandom), 4'($urandom), 1'b0);
  endtask

  initial begin
    n_pass   = 0;
    n_total  = 0;
    cyc      = 0;
    rst      = 1'b1;
    sel      = '0;
    in       = '0;
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      la[i] = '0;
      lb[i] = '0;
    end
    lc = '0;

    // Reset state, with a live-looking word on the inputs that must be ignored.
    step(1'b1, 4'd3, 4'hF, 1'b1);
    step(1'b0, 4'd0, 4'h0, 1'b1);
    idle(2);

    // Single word to lane 7.
    step(1'b1, 4'd7, 4'hA, 1'b0);
    idle(5);

    // Sweep every lane back to back, data equals lane index.
    for (int s = 0; s < 10; s++) step(1'b1, 4'(s), 4'(s), 1'b0);
    idle(5);

    // Out-of-range selects become drop tokens.
    step(1'b1, 4'd12, 4'h3, 1'b0);
    idle(1);
    step(1'b1, 4'd10, 4'h6, 1'b0);
    step(1'b1, 4'd15, 4'h9, 1'b0);
    step(1'b1, 4'd2, 4'hC, 1'b0);
    idle(5);

    // Alternate the two extreme lanes every cycle.
    for (int i = 0; i < 8; i++) step(1'b1, (i % 2 == 0) ? 4'd9 : 4'd0, 4'(i + 1), 1'b0);
    idle(5);

    // Reset in the middle of a stream, then one word afterwards.
    for (int i = 0; i < 6; i++) step(1'b1, 4'($urandom_range(0, 9)), 4'($urandom), 1'b0);
    step(1'b1, 4'd4, 4'h7, 1'b1);
    step(1'b1, 4'd5, 4'hB, 1'b0);
    idle(6);

    // Randomized traffic with occasional drops, bubbles and resets.
    for (int i = 0; i < 300; i++)
      step(($urandom % 4) != 0, 4'($urandom), 4'($urandom), ($urandom % 60) == 0);
    idle(6);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
